// File: rtl/key_debounce_pkg.sv
// key_debounce_pkg: shared FSM state type and default timing constants for the key debouncer.
package key_debounce_pkg;

    typedef enum logic [1:0] {UP, CHK_DN, DOWN, CHK_UP} state_t;

    localparam int DB_CYCLES_50MHZ_20MS = 1000000;
    localparam int LONG_CYCLES_50MHZ_1S = 50000000;

endpackage

// File: rtl/key_debounce_channel.sv
// key_debounce_channel: synchroniser, debounce FSM and strobes for one active-low key.
// Long-press strobe is built only when KEY_LONG_PRESS_EN is defined.
module key_debounce_channel
    import key_debounce_pkg::*;
#(
    parameter int DB_CYCLES   = DB_CYCLES_50MHZ_20MS,
    parameter int LONG_CYCLES = LONG_CYCLES_50MHZ_1S
) (
    input  logic CLOCK_50,
    input  logic reset_n,
    input  logic key,
    output logic key_level,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam int CW = $clog2(DB_CYCLES);

    logic [1:0]    sync;
    logic          sync_pressed;
    state_t        state, state_nxt;
    logic [CW-1:0] count, count_nxt;
    logic          count_done;

    assign sync_pressed = ~sync[1];
    assign count_done   = count == CW'(DB_CYCLES - 1);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n)
            sync <= 2'b11;
        else
            sync <= {sync[0], key};
    end

    // Checking states count stable samples; any disagreement falls back without a strobe.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        case (state)
            UP:
                if (sync_pressed) begin
                    state_nxt = CHK_DN;
                    count_nxt = '0;
                end
            CHK_DN:
                if (!sync_pressed) begin
                    state_nxt = UP;
                    count_nxt = '0;
                end else if (count_done)
                    state_nxt = DOWN;
                else
                    count_nxt = count + CW'(1);
            DOWN:
                if (!sync_pressed) begin
                    state_nxt = CHK_UP;
                    count_nxt = '0;
                end
            CHK_UP:
                if (sync_pressed) begin
                    state_nxt = DOWN;
                    count_nxt = '0;
                end else if (count_done)
                    state_nxt = UP;
                else
                    count_nxt = count + CW'(1);
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= UP;
            count       <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            key_level   <= state_nxt == DOWN || state_nxt == CHK_UP;
            key_press   <= state == CHK_DN && state_nxt == DOWN;
            key_release <= state == CHK_UP && state_nxt == UP;
        end
    end

`ifdef KEY_LONG_PRESS_EN
    localparam int LW = $clog2(LONG_CYCLES);

    logic [LW-1:0] long_count;
    logic          long_done;

    // Any state other than DOWN clears the timer, so each entry to DOWN starts fresh.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            long_count <= '0;
            long_done  <= 1'b0;
            key_long   <= 1'b0;
        end else if (state != DOWN) begin
            long_count <= '0;
            long_done  <= 1'b0;
            key_long   <= 1'b0;
        end else begin
            key_long <= long_count == LW'(LONG_CYCLES - 1) && !long_done;
            if (long_count == LW'(LONG_CYCLES - 1))
                long_done <= 1'b1;
            else
                long_count <= long_count + LW'(1);
        end
    end
`else
    assign key_long = 1'b0;
`endif

endmodule

// File: rtl/key_debounce.sv
// key_debounce: debounced level and press/release/long strobes for NUM_KEYS active-low keys.
// Long-press strobes require KEY_LONG_PRESS_EN; otherwise key_long is tied low.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int NUM_KEYS    = 4,
    parameter int DB_CYCLES   = DB_CYCLES_50MHZ_20MS,
    parameter int LONG_CYCLES = LONG_CYCLES_50MHZ_1S
) (
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic [NUM_KEYS-1:0] KEY,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic [NUM_KEYS-1:0] key_long
);

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_channel #(
            .DB_CYCLES  (DB_CYCLES),
            .LONG_CYCLES(LONG_CYCLES)
        ) u_channel (
            .CLOCK_50   (CLOCK_50),
            .reset_n    (reset_n),
            .key        (KEY[i]),
            .key_level  (key_level[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i]),
            .key_long   (key_long[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: directed checks of debounce latency, bounce rejection, reset and long press.
module tb_key_debounce;

`ifdef KEY_LONG_PRESS_EN
    localparam bit LONG_ON = 1'b1;
`else
    localparam bit LONG_ON = 1'b0;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       reset_n;
    logic [3:0] KEY;
    logic [3:0] key_level, key_press, key_release, key_long;

    int vectors = 0;
    int miscompares = 0;

    key_debounce #(
        .NUM_KEYS   (4),
        .DB_CYCLES  (8),
        .LONG_CYCLES(20)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset_n    (reset_n),
        .KEY        (KEY),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release),
        .key_long   (key_long)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        KEY     = 4'b1111;
        step(3);
        chk("rst_level", key_level, 4'b0000);
        chk("rst_press", key_press, 4'b0000);
        chk("rst_release", key_release, 4'b0000);
        chk("rst_long", key_long, 4'b0000);
        reset_n = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step(1);
            chk("idle_all", key_level | key_press | key_release | key_long, 4'b0000);
        end

        KEY[0] = 1'b0;
        step(10);
        chk("k0_level_e10", key_level, 4'b0000);
        chk("k0_press_e10", key_press, 4'b0000);
        step(1);
        chk("k0_level_e11", key_level, 4'b0001);
        chk("k0_press_e11", key_press, 4'b0001);
        step(1);
        chk("k0_level_e12", key_level, 4'b0001);
        chk("k0_press_e12", key_press, 4'b0000);

        KEY[0] = 1'b1;
        step(3);
        KEY[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("k0_glitch_level", key_level, 4'b0001);
            chk("k0_glitch_release", key_release, 4'b0000);
            chk("k0_glitch_long", key_long, 4'b0000);
        end

        KEY[0] = 1'b1;
        step(10);
        chk("k0_rel_level_e10", key_level, 4'b0001);
        chk("k0_rel_release_e10", key_release, 4'b0000);
        step(1);
        chk("k0_rel_level_e11", key_level, 4'b0000);
        chk("k0_rel_release_e11", key_release, 4'b0001);
        step(1);
        chk("k0_rel_release_e12", key_release, 4'b0000);
        chk("k0_short_no_long", key_long, 4'b0000);

        for (int r = 0; r < 2; r++) begin
            KEY[1] = 1'b0;
            for (int i = 0; i < 5; i++) begin
                step(1);
                chk("k1_bounce_level", key_level, 4'b0000);
                chk("k1_bounce_press", key_press, 4'b0000);
            end
            KEY[1] = 1'b1;
            for (int i = 0; i < 2; i++) begin
                step(1);
                chk("k1_bounce_level", key_level, 4'b0000);
                chk("k1_bounce_press", key_press, 4'b0000);
            end
        end
        KEY[1] = 1'b0;
        step(10);
        chk("k1_level_e10", key_level, 4'b0000);
        step(1);
        chk("k1_level_e11", key_level, 4'b0010);
        chk("k1_press_e11", key_press, 4'b0010);
        step(1);
        chk("k1_press_e12", key_press, 4'b0000);
        KEY[1] = 1'b1;
        step(10);
        chk("k1_release_e10", key_release, 4'b0000);
        step(1);
        chk("k1_release_e11", key_release, 4'b0010);
        chk("k1_rel_level", key_level, 4'b0000);
        step(1);
        chk("k1_release_e12", key_release, 4'b0000);
        chk("k1_no_long", key_long, 4'b0000);

        KEY[3] = 1'b0;
        step(11);
        chk("k3_press", key_press, 4'b1000);
        step(19);
        chk("k3_long_early", key_long, 4'b0000);
        step(1);
        chk("k3_long_pulse", key_long, LONG_ON ? 4'b1000 : 4'b0000);
        step(1);
        chk("k3_long_end", key_long, 4'b0000);
        for (int i = 0; i < 25; i++) begin
            step(1);
            chk("k3_long_no_repeat", key_long, 4'b0000);
            chk("k3_level_hold", key_level, 4'b1000);
        end

        KEY[2] = 1'b0;
        step(5);
        chk("k2_chkdn_level", key_level, 4'b1000);
        reset_n = 1'b0;
        #2;
        chk("async_rst_level", key_level, 4'b0000);
        chk("async_rst_press", key_press, 4'b0000);
        step(1);
        reset_n = 1'b1;
        step(10);
        chk("post_rst_level_e10", key_level, 4'b0000);
        step(1);
        chk("post_rst_level_e11", key_level, 4'b1100);
        chk("post_rst_press_e11", key_press, 4'b1100);
        step(1);
        chk("post_rst_press_e12", key_press, 4'b0000);
        step(18);
        chk("post_rst_long_early", key_long, 4'b0000);
        step(1);
        chk("post_rst_long", key_long, LONG_ON ? 4'b1100 : 4'b0000);
        step(1);
        chk("post_rst_long_end", key_long, 4'b0000);

        KEY = 4'b1111;
        step(11);
        chk("final_release", key_release, 4'b1100);
        step(1);
        chk("final_level", key_level, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
